keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x4 matrix hex keypad and returns one debounced 4-bit key code per press.
//   This is the input-side counterpart of the multiplexed seven-segment driver. That
//   driver strobes anodes outward; this block strobes columns outward and reads rows
//   back. It produces values that the counter/display path consumes.
// PARAMETERS
//   SCAN_DIV        100000  clk_100MHz cycles per column dwell (1 ms); must be >= 4
//   DEBOUNCE_SCANS  4       consecutive identical full scans needed to accept a press or release
// PORTS
//   clk_100MHz  in   1  system clock
//   reset       in   1  asynchronous, active-low reset
//   row         in   4  keypad rows, active-low (pulled up externally), asynchronous
//   col         out  4  keypad column drive, active-low, exactly one bit low at a time
//   key_code    out  4  code of last accepted key; held until next accepted press
//   key_valid   out  1  one-cycle pulse when a new key is accepted
//   key_held    out  1  high from acceptance until release is debounced
// BEHAVIOUR
//   - Reset (reset=0, async): col=4'b1110, column index=0, dwell counter=0.
//     Also key_code=0, key_valid=0, key_held=0, FSM=IDLE, debounce count=0.
//   - row passes through a 2-FF synchronizer before any use.
//   - Dwell counter runs 0..SCAN_DIV-1. On its last cycle the synchronized row is
//     sampled for the current column. The column index then advances 0->1->2->3->0.
//     col = ~(4'b0001 << index).
//   - A full scan is 4 dwells. At the end of a scan, the result is classified:
//     NONE (no low row bits in any column), SINGLE(code) (exactly one), or MULTI (two or more).
//   - Key map, row r / col c (r=0..3 down, c=0..3 across):
//       r0: 1 2 3 A
//       r1: 4 5 6 B
//       r2: 7 8 9 C
//       r3: 0 F E D
//   - FSM. Updates happen only at scan end; count = debounce count.
//     IDLE:     SINGLE(k) -> DEBOUNCE, cand=k, count=1. NONE/MULTI -> stay.
//     DEBOUNCE: SINGLE(cand) -> count+1; on reaching DEBOUNCE_SCANS -> PRESSED.
//               SINGLE(k!=cand) -> stay in DEBOUNCE, cand=k, count=1.
//               NONE/MULTI -> IDLE.
//     PRESSED:  NONE -> RELEASE, count=1. SINGLE/MULTI -> stay.
//               No auto-repeat; a second key pressed while held is ignored.
//     RELEASE:  NONE -> count+1; on reaching DEBOUNCE_SCANS -> IDLE, key_held=0.
//               SINGLE/MULTI -> PRESSED (no new pulse).
//   - On the DEBOUNCE->PRESSED transition, in the same cycle:
//     key_code<=cand, key_held<=1, key_valid=1 for exactly one clock.
//   - Latency from a stable press to key_valid: between DEBOUNCE_SCANS and
//     DEBOUNCE_SCANS+1 full scans, plus 2 synchronizer cycles.
//   - With DEBOUNCE_SCANS=1, a press is accepted on its first SINGLE scan and a release
//     on its first NONE scan.
//   - The debounce count saturates at DEBOUNCE_SCANS and never wraps.
//   - Dwell and column counters wrap freely and are independent of FSM state.
//   - Reset asserted mid-scan or mid-press aborts immediately to reset values.
//     No key_valid is produced for a press in progress at reset.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=2, so 1 scan = 16 clocks)
//   1. Assert reset mid-dwell with key '5' held -> col=1110, key_code=0, key_valid=0,
//      key_held=0 asynchronously; scanning restarts at column 0 after release of reset.
//   2. Hold '5' (row1 low while col1 low) for 4 scans -> exactly one key_valid pulse,
//      key_code=4'h5, key_held=1; no further pulses while held.
//   3. '9' pressed 1 scan, released 1 scan, then held -> single pulse, key_code=4'h9,
//      occurring only after 2 consecutive SINGLE(9) scans.
//   4. '1' and 'D' pressed together for 5 scans -> no key_valid; key_code unchanged.
//   5. Hold 'A', release 1 scan, re-press -> no second pulse and key_held stays 1.
//      Release 2 scans -> key_held=0. Re-press 'A' -> new pulse with code 4'hA.
//   6. Sweep all 16 keys, each held 3 scans with a 3-scan release between ->
//      key_code matches the map for each key (e.g. r3c0=4'h0, r3c3=4'hD).
//      col is always one-hot-low.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 hex keypad column scanner with debounced single-key output
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = '0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    // Row/column position to hex legend of the keypad.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;
            4'b11_01: k = 4'hF;
            4'b11_10: k = 4'hE;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    logic [3:0]    row_meta_q, row_sync_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    idx_q;
    logic [3:0]    col_q;
    logic [1:0]    hits_q;
    logic [3:0]    code_q;
    state_t        state_q;
    logic [3:0]    cand_q;
    logic [CW-1:0] count_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_held_q;

    logic          dwell_last;
    logic          scan_end;
    logic [3:0]    row_low;
    logic [2:0]    col_hits;
    logic [1:0]    row_pos;
    logic [1:0]    hits_d;
    logic [3:0]    code_d;
    logic [1:0]    idx_d;
    logic          scan_none;
    logic          scan_single;
    logic [CW-1:0] count_inc;

    // Two-stage synchronizer for the asynchronous, externally pulled-up rows.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Decode the current column's sample and fold it into this scan's running result.
    always_comb begin
        dwell_last = (dwell_q == DWELL_LAST);
        scan_end   = dwell_last && (idx_q == 2'd3);
        row_low    = ~row_sync_q;
        col_hits   = {2'b00, row_low[0]} + {2'b00, row_low[1]}
                   + {2'b00, row_low[2]} + {2'b00, row_low[3]};
        row_pos    = 2'd0;
        if (row_low[3]) row_pos = 2'd3;
        if (row_low[2]) row_pos = 2'd2;
        if (row_low[1]) row_pos = 2'd1;
        if (row_low[0]) row_pos = 2'd0;
        // hits saturates at 2, which already means "more than one key"
        if (col_hits >= 3'd2)
            hits_d = 2'd2;
        else if (col_hits == 3'd1)
            hits_d = (hits_q == 2'd0) ? 2'd1 : 2'd2;
        else
            hits_d = hits_q;
        code_d      = (col_hits != 3'd0) ? key_map(row_pos, idx_q) : code_q;
        idx_d       = dwell_last ? idx_q + 2'd1 : idx_q;
        scan_none   = (hits_d == 2'd0);
        scan_single = (hits_d == 2'd1);
        count_inc   = (count_q >= DB_MAX) ? count_q : count_q + CNT_ONE;
    end

    // Free-running dwell counter, column index and registered column drive.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            dwell_q <= '0;
            idx_q   <= 2'd0;
            col_q   <= 4'b1110;
        end else begin
            dwell_q <= dwell_last ? '0 : dwell_q + DW'(1);
            idx_q   <= idx_d;
            col_q   <= ~(4'b0001 << idx_d);
        end
    end

    // Per-scan accumulator, cleared as each full scan is handed to the FSM.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            hits_q <= 2'd0;
            code_q <= 4'h0;
        end else if (dwell_last) begin
            hits_q <= scan_end ? 2'd0 : hits_d;
            code_q <= scan_end ? 4'h0 : code_d;
        end
    end

    // Press/release debounce FSM, stepped once per completed scan, with registered outputs.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cand_q      <= 4'h0;
            count_q     <= CNT_ZERO;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_end) begin
                case (state_q)
                    S_IDLE: begin
                        if (scan_single) begin
                            cand_q  <= code_d;
                            count_q <= CNT_ONE;
                            if (CNT_ONE >= DB_MAX) begin
                                state_q     <= S_PRESSED;
                                key_code_q  <= code_d;
                                key_held_q  <= 1'b1;
                                key_valid_q <= 1'b1;
                            end else begin
                                state_q <= S_DEBOUNCE;
                            end
                        end
                    end
                    S_DEBOUNCE: begin
                        if (scan_single && (code_d == cand_q)) begin
                            count_q <= count_inc;
                            if (count_inc >= DB_MAX) begin
                                state_q     <= S_PRESSED;
                                key_code_q  <= cand_q;
                                key_held_q  <= 1'b1;
                                key_valid_q <= 1'b1;
                            end
                        end else if (scan_single) begin
                            cand_q  <= code_d;
                            count_q <= CNT_ONE;
                        end else begin
                            state_q <= S_IDLE;
                            count_q <= CNT_ZERO;
                        end
                    end
                    S_PRESSED: begin
                        // a second key while held is ignored: no auto-repeat
                        if (scan_none) begin
                            if (CNT_ONE >= DB_MAX) begin
                                state_q    <= S_IDLE;
                                count_q    <= CNT_ZERO;
                                key_held_q <= 1'b0;
                            end else begin
                                state_q <= S_RELEASE;
                                count_q <= CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        if (scan_none) begin
                            count_q <= count_inc;
                            if (count_inc >= DB_MAX) begin
                                state_q    <= S_IDLE;
                                count_q    <= CNT_ZERO;
                                key_held_q <= 1'b0;
                            end
                        end else begin
                            // bounce during release: back to held without a new pulse
                            state_q <= S_PRESSED;
                            count_q <= CNT_ZERO;
                        end
                    end
                endcase
            end
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

    localparam int SCAN = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;

    int errors = 0;
    int checks = 0;
    int pulse_count = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [15:0] mask;
        int          hold;
        int          rel;
        bit          pulse;
        logic [3:0]  code;
        bit          held;
    } vec_t;

    vec_t vecs[$];

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clk_100MHz(clk),
        .reset     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column line.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        chk("col_one_hot_low", 32'($countones(~col)), 1);
        if (rst_n && key_valid) begin
            pulse_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {28'd0, key_code}, 32'hFFFF_FFFF);
            end else begin
                chk("pulse_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
                chk("held_at_pulse", {31'd0, key_held}, 1);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic scans(input int n);
        repeat (n * SCAN) tick();
    endtask

    initial begin
        int p0;
        rst_n   = 1'b0;
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_col", {28'd0, col}, 4'b1110);
        chk("reset_code", {28'd0, key_code}, 0);
        chk("reset_valid", {31'd0, key_valid}, 0);
        chk("reset_held", {31'd0, key_held}, 0);
        rst_n = 1'b1;

        // '5' held 4 scans, '1'+'D' together, then all 16 keys
        vecs.push_back('{16'h0020, 4, 3, 1'b1, 4'h5, 1'b1});
        vecs.push_back('{16'h8001, 5, 3, 1'b0, 4'h5, 1'b0});
        for (int i = 0; i < 16; i++)
            vecs.push_back('{16'(1) << i, 3, 3, 1'b1, kmap[i], 1'b1});

        foreach (vecs[i]) begin
            if (vecs[i].pulse) exp_q.push_back(vecs[i].code);
            pressed = vecs[i].mask;
            scans(vecs[i].hold);
            chk($sformatf("code_v%0d", i), {28'd0, key_code}, {28'd0, vecs[i].code});
            chk($sformatf("held_v%0d", i), {31'd0, key_held}, {31'd0, vecs[i].held});
            pressed = 16'h0;
            scans(vecs[i].rel);
            chk($sformatf("released_v%0d", i), {31'd0, key_held}, 0);
            chk($sformatf("drained_v%0d", i), 32'(exp_q.size()), 0);
        end

        // '9' for one scan, released one scan, then held: pulse only after two SINGLE(9)
        pressed = 16'h0400;
        scans(1);
        pressed = 16'h0;
        scans(1);
        p0 = pulse_count;
        chk("nine_no_early_pulse", 32'(pulse_count), 32'(p0));
        pressed = 16'h0400;
        exp_q.push_back(4'h9);
        scans(1);
        chk("nine_wait_one_scan", 32'(pulse_count), 32'(p0));
        scans(1);
        chk("nine_pulse_after_two", 32'(pulse_count), 32'(p0 + 1));
        chk("nine_code", {28'd0, key_code}, 4'h9);
        pressed = 16'h0;
        scans(3);

        // 'A' bounce during release gives no second pulse
        pressed = 16'h0008;
        exp_q.push_back(4'hA);
        scans(3);
        p0 = pulse_count;
        pressed = 16'h0;
        scans(1);
        pressed = 16'h0008;
        scans(2);
        chk("a_rebounce_no_pulse", 32'(pulse_count), 32'(p0));
        chk("a_rebounce_held", {31'd0, key_held}, 1);
        pressed = 16'h0;
        scans(2);
        chk("a_release_held", {31'd0, key_held}, 0);
        pressed = 16'h0008;
        exp_q.push_back(4'hA);
        scans(3);
        chk("a_repress_pulse", 32'(pulse_count), 32'(p0 + 1));
        chk("a_repress_code", {28'd0, key_code}, 4'hA);
        pressed = 16'h0;
        scans(3);

        // reset mid-dwell with '5' held aborts the press
        pressed = 16'h0020;
        p0 = pulse_count;
        scans(1);
        repeat (6) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_col", {28'd0, col}, 4'b1110);
        chk("async_reset_code", {28'd0, key_code}, 0);
        chk("async_reset_valid", {31'd0, key_valid}, 0);
        chk("async_reset_held", {31'd0, key_held}, 0);
        pressed = 16'h0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("restart_col0", {28'd0, col}, 4'b1110);
        tick();
        chk("restart_col1", {28'd0, col}, 4'b1101);
        scans(4);
        chk("post_reset_code", {28'd0, key_code}, 0);
        chk("post_reset_held", {31'd0, key_held}, 0);
        chk("post_reset_no_pulse", 32'(pulse_count), 32'(p0));
        chk("final_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
